gb_bus_arbiter: RTL and testbench

//  Shares one ghostbus-style local bus (addr/din/dout/we) between NREQ

---
 rtl/gb_bus_arbiter_pkg.sv | 18 +
 rtl/gb_bus_arbiter_rr_pick.sv | 33 +++
 rtl/gb_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_gb_bus_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_bus_arbiter_pkg.sv
// Shared types for the ghostbus arbiter: FSM encoding and width helpers.
package gb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CNT_W = 3;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gb_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, with wrap.
module gb_bus_arbiter_rr_pick
  import gb_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx
);

  logic hit;
  int   c;

  always_comb begin
    pick = '0;
    idx  = '0;
    hit  = 1'b0;
    c    = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!hit && req[c[IW-1:0]]) begin
        hit            = 1'b1;
        pick[c[IW-1:0]] = 1'b1;
        idx            = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/gb_bus_arbiter.sv
// Round-robin owner of one ghostbus: one transaction in flight, fixed read latency.
module gb_bus_arbiter
  import gb_bus_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int RD_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_din,
  output logic [NREQ-1:0]   req_ack,
  output logic [DW-1:0]     req_dout,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [AW-1:0]     addr,
  output logic [DW-1:0]     din,
  output logic              we,
  input  logic [DW-1:0]     dout
);

  localparam int IW = idx_w(NREQ);
  localparam int LD = (RD_DELAY > 0) ? RD_DELAY - 1 : 0;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(LD);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [CNT_W-1:0] cnt;
  logic            wr;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_din;
  logic            sel_we;
  logic [IW-1:0]   ptr_nxt;

  gb_bus_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign sel_addr = req_addr[int'(pick_idx)*AW +: AW];
  assign sel_din  = req_din[int'(pick_idx)*DW +: DW];
  assign sel_we   = req_we[pick_idx];

  // Wraps to 0 after the top requester; pins to 0 when NREQ=1.
  assign ptr_nxt = (int'(owner) == NREQ - 1) ?
                   '0 : owner + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      wr       <= 1'b0;
      req_ack  <= '0;
      req_dout <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      addr     <= '0;
      din      <= '0;
      we       <= 1'b0;
    end else begin
      req_ack <= '0;
      we      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            owner <= pick_idx;
            gnt   <= pick;
            addr  <= sel_addr;
            din   <= sel_din;
            wr    <= sel_we;
            we    <= sel_we;
            busy  <= 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wr) begin
            req_ack <= gnt;
            state   <= ST_DONE;
          end else if (RD_DELAY == 0) begin
            req_ack  <= gnt;
            req_dout <= dout;
            state    <= ST_DONE;
          end else begin
            cnt   <= WAIT_LD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            req_ack  <= gnt;
            req_dout <= dout;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          ptr   <= ptr_nxt;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gb_bus_arbiter.sv
// Scoreboard bench: a two-requester arbiter with slow reads, plus a
// single-requester arbiter with zero-latency reads.
module tb_gb_bus_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;

  typedef struct {
    int         idx;
    bit         rd;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  logic [1:0]      a_req, a_we, a_ack, a_gnt;
  logic [2*AW-1:0] a_addr;
  logic [2*DW-1:0] a_din;
  logic [DW-1:0]   a_rdout, a_bdin, a_bdout;
  logic [AW-1:0]   a_baddr;
  logic            a_bwe, a_busy;
  logic [AW-1:0]   a_pipe [3];

  logic [0:0]      b_req, b_we, b_ack, b_gnt;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_din;
  logic [DW-1:0]   b_rdout, b_bdin, b_bdout;
  logic [AW-1:0]   b_baddr;
  logic            b_bwe, b_busy;

  gb_bus_arbiter #(
    .NREQ(2), .AW(AW), .DW(DW), .RD_DELAY(3)
  ) u_a (
    .clk(clk), .rst(rst),
    .req(a_req), .req_we(a_we),
    .req_addr(a_addr), .req_din(a_din),
    .req_ack(a_ack), .req_dout(a_rdout),
    .gnt(a_gnt), .busy(a_busy),
    .addr(a_baddr), .din(a_bdin),
    .we(a_bwe), .dout(a_bdout)
  );

  gb_bus_arbiter #(
    .NREQ(1), .AW(AW), .DW(DW), .RD_DELAY(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .req(b_req), .req_we(b_we),
    .req_addr(b_addr), .req_din(b_din),
    .req_ack(b_ack), .req_dout(b_rdout),
    .gnt(b_gnt), .busy(b_busy),
    .addr(b_baddr), .din(b_bdin),
    .we(b_bwe), .dout(b_bdout)
  );

  // Bus A returns data 3 cycles after the address; bus B is immediate.
  always @(posedge clk) begin
    a_pipe[0] <= a_baddr;
    a_pipe[1] <= a_pipe[0];
    a_pipe[2] <= a_pipe[1];
  end
  assign a_bdout = {8'h00, a_pipe[2]} ^ 32'hA5A5A5A5;
  assign b_bdout = {8'h00, b_baddr} ^ 32'h5A5A5A5A;

  function automatic logic [DW-1:0] a_rd(input logic [AW-1:0] a);
    return {8'h00, a} ^ 32'hA5A5A5A5;
  endfunction

  function automatic logic [DW-1:0] b_rd(input logic [AW-1:0] a);
    return {8'h00, a} ^ 32'h5A5A5A5A;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired run=%0d", n_run);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_din = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_din = '0;
    repeat (3) @(negedge clk);
    n_run++;
    if ({a_ack, a_gnt, a_busy, a_bwe, a_baddr, a_bdin, a_rdout} !== '0) begin
      n_fail++;
      $display("FAIL reset_a got ack=%b gnt=%b busy=%b we=%b addr=%h din=%h dout=%h exp all 0",
               a_ack, a_gnt, a_busy, a_bwe, a_baddr, a_bdin, a_rdout);
    end
    n_run++;
    if ({b_ack, b_gnt, b_busy, b_bwe, b_baddr, b_bdin, b_rdout} !== '0) begin
      n_fail++;
      $display("FAIL reset_b got ack=%b gnt=%b busy=%b we=%b addr=%h exp all 0",
               b_ack, b_gnt, b_busy, b_bwe, b_baddr);
    end
    rst = 1'b0;
    @(negedge clk);
    // Read from requester 0, then reset while it waits on the bus.
    a_req = 2'b01; a_we = 2'b00;
    a_addr[0 +: AW] = 24'h000123;
    @(negedge clk);
    n_run++;
    if (a_busy !== 1'b1 || a_gnt !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_pre_busy got busy=%b gnt=%b exp 1 01", a_busy, a_gnt);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_run++;
    if ({a_ack, a_gnt, a_busy, a_bwe, a_baddr, a_rdout} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_read got gnt=%b busy=%b addr=%h exp 0", a_gnt, a_busy, a_baddr);
    end
    a_req = '0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack !== 2'b00 || a_busy !== 1'b0) seen = 1'b1;
    end
    n_run++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_no_ack got ack_or_busy=1 exp 0");
    end
    // Write from requester 1, reset while we is high.
    a_req = 2'b10; a_we = 2'b10;
    a_addr[AW +: AW] = 24'h000456;
    a_din[DW +: DW] = 32'h11112222;
    @(negedge clk);
    n_run++;
    if (a_bwe !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_we got we=%b exp 1", a_bwe);
    end
    #1 rst = 1'b1;
    #1;
    n_run++;
    if (a_bwe !== 1'b0 || a_gnt !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_write got we=%b gnt=%b exp 0 00", a_bwe, a_gnt);
    end
    a_req = '0; a_we = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    exp_t e;
    int we_cnt = 0, we_at = -1, ack_at = -1;
    a_req = 2'b01; a_we = 2'b01;
    a_addr[0 +: AW] = 24'h000010;
    a_din[0 +: DW] = 32'hDEADBEEF;
    sb.push_back('{0, 1'b0, 32'h0});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_bwe === 1'b1) begin we_cnt++; we_at = k; end
      if (k == 1) begin
        n_run++;
        if (a_baddr !== 24'h000010 || a_bdin !== 32'hDEADBEEF || a_gnt !== 2'b01) begin
          n_fail++;
          $display("FAIL wr_bus got addr=%h din=%h gnt=%b exp 000010 deadbeef 01",
                   a_baddr, a_bdin, a_gnt);
        end
        a_req = 2'b00;
      end
      if (a_ack !== 2'b00 && ack_at < 0) begin
        ack_at = k;
        if (sb.size() > 0) e = sb.pop_front();
        n_run++;
        if (a_ack !== 2'(1 << e.idx) || a_rdout !== e.data) begin
          n_fail++;
          $display("FAIL wr_ack got ack=%b dout=%h exp idx=%0d dout=%h",
                   a_ack, a_rdout, e.idx, e.data);
        end
      end
    end
    n_run++;
    if (we_cnt != 1 || we_at != 1 || ack_at != 2) begin
      n_fail++;
      $display("FAIL wr_timing got we_cnt=%0d we_at=%0d ack_at=%0d exp 1 1 2",
               we_cnt, we_at, ack_at);
    end
    n_run++;
    if (a_busy !== 1'b0 || a_gnt !== 2'b00 || a_baddr !== 24'h000010) begin
      n_fail++;
      $display("FAIL wr_after got busy=%b gnt=%b addr=%h exp 0 00 000010",
               a_busy, a_gnt, a_baddr);
    end
  endtask

  task automatic test_read_delay();
    exp_t e;
    int we_cnt = 0, ack_at = -1;
    logic [DW-1:0] held;
    a_req = 2'b01; a_we = 2'b00;
    a_addr[0 +: AW] = 24'h001234;
    sb.push_back('{0, 1'b1, a_rd(24'h001234)});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) a_req = 2'b00;
      if (a_bwe === 1'b1) we_cnt++;
      if (a_ack !== 2'b00 && ack_at < 0) begin
        ack_at = k;
        if (sb.size() > 0) e = sb.pop_front();
        n_run++;
        if (a_ack !== 2'(1 << e.idx) || a_rdout !== e.data) begin
          n_fail++;
          $display("FAIL rd_ack got ack=%b dout=%h exp idx=%0d dout=%h",
                   a_ack, a_rdout, e.idx, e.data);
        end
      end
    end
    n_run++;
    if (ack_at != 5 || we_cnt != 0) begin
      n_fail++;
      $display("FAIL rd_timing got ack_at=%0d we_cnt=%0d exp 5 0", ack_at, we_cnt);
    end
    held = a_rd(24'h001234);
    n_run++;
    if (a_rdout !== held) begin
      n_fail++;
      $display("FAIL rd_hold got %h exp %h", a_rdout, held);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int p = 0, grants = 0, acks = 0, last_g = 0;
    logic [1:0] prev = 2'b00;
    logic [AW-1:0] ad [2];
    logic [DW-1:0] dd [2];
    ad[0] = 24'h000100; ad[1] = 24'h000200;
    dd[0] = 32'hA0A00000; dd[1] = 32'hB1B10001;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_req = 2'b11; a_we = 2'b11;
    a_addr = {ad[1], ad[0]};
    a_din = {dd[1], dd[0]};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{p, 1'b0, 32'h0});
      p = (p + 1) % 2;
    end
    for (int k = 1; k <= 60 && acks < 6; k++) begin
      @(negedge clk);
      if (a_gnt !== 2'b00 && prev === 2'b00) begin
        grants++;
        if (grants > 1) begin
          n_run++;
          if (k - last_g != 3) begin
            n_fail++;
            $display("FAIL rr_spacing got %0d exp 3", k - last_g);
          end
        end
        last_g = k;
        n_run++;
        if (a_bwe !== 1'b1 || a_bdin !== dd[a_gnt[1]]) begin
          n_fail++;
          $display("FAIL rr_issue got we=%b din=%h gnt=%b", a_bwe, a_bdin, a_gnt);
        end
        if (grants == 6) a_req = 2'b00;
      end
      prev = a_gnt;
      if (a_ack !== 2'b00) begin
        acks++;
        if (sb.size() > 0) e = sb.pop_front();
        n_run++;
        if (a_ack !== 2'(1 << e.idx) || a_baddr !== ad[e.idx] || a_rdout !== 32'h0) begin
          n_fail++;
          $display("FAIL rr_ack%0d got ack=%b addr=%h dout=%h exp idx=%0d addr=%h dout=0",
                   acks, a_ack, a_baddr, a_rdout, e.idx, ad[e.idx]);
        end
      end
    end
    n_run++;
    if (acks != 6 || grants != 6) begin
      n_fail++;
      $display("FAIL rr_count got acks=%0d grants=%0d exp 6 6", acks, grants);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_after_grant();
    exp_t e;
    int ack_at = -1;
    bit idle_bad = 1'b0;
    a_req = 2'b10; a_we = 2'b00;
    a_addr[AW +: AW] = 24'h0000AB;
    sb.push_back('{1, 1'b1, a_rd(24'h0000AB)});
    for (int k = 1; k <= 12 && ack_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_run++;
        if (a_gnt !== 2'b10) begin
          n_fail++;
          $display("FAIL drop_gnt got %b exp 10", a_gnt);
        end
        a_req = 2'b00;
      end
      if (a_ack !== 2'b00) begin
        ack_at = k;
        if (sb.size() > 0) e = sb.pop_front();
        n_run++;
        if (a_ack !== 2'(1 << e.idx) || a_rdout !== e.data) begin
          n_fail++;
          $display("FAIL drop_ack got ack=%b dout=%h exp idx=%0d dout=%h",
                   a_ack, a_rdout, e.idx, e.data);
        end
      end
    end
    n_run++;
    if (ack_at != 5) begin
      n_fail++;
      $display("FAIL drop_timing got ack_at=%0d exp 5", ack_at);
    end
    repeat (3) begin
      @(negedge clk);
      if (a_busy !== 1'b0 || a_gnt !== 2'b00) idle_bad = 1'b1;
    end
    n_run++;
    if (idle_bad) begin
      n_fail++;
      $display("FAIL drop_idle got busy_or_gnt=1 exp 0");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int grants = 0, acks = 0, last_a = 0, ack_at = -1;
    logic prev = 1'b0;
    logic [DW-1:0] saved;
    logic [AW-1:0] lst [4];
    lst[0] = 24'h000001; lst[1] = 24'h0ABCDE;
    lst[2] = 24'hFFFFFF; lst[3] = 24'h123456;
    b_req = 1'b1; b_we = 1'b0;
    b_addr = lst[0];
    sb.push_back('{0, 1'b1, b_rd(lst[0])});
    for (int k = 1; k <= 40 && acks < 4; k++) begin
      @(negedge clk);
      // New address is presented right after each grant; it must not
      // disturb the transaction already latched.
      if (b_gnt === 1'b1 && prev === 1'b0) begin
        grants++;
        if (grants < 4) begin
          b_addr = lst[grants];
          sb.push_back('{0, 1'b1, b_rd(lst[grants])});
        end else begin
          b_req = 1'b0;
        end
      end
      prev = b_gnt[0];
      if (b_ack === 1'b1) begin
        if (sb.size() > 0) e = sb.pop_front();
        n_run++;
        if (b_rdout !== e.data) begin
          n_fail++;
          $display("FAIL b2b_data%0d got %h exp %h", acks, b_rdout, e.data);
        end
        if (acks > 0) begin
          n_run++;
          if (k - last_a != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing got %0d exp 3", k - last_a);
          end
        end
        last_a = k;
        acks++;
      end
    end
    n_run++;
    if (acks != 4) begin
      n_fail++;
      $display("FAIL b2b_count got %0d exp 4", acks);
    end
    @(negedge clk);
    saved = b_rd(lst[3]);
    b_req = 1'b1; b_we = 1'b1;
    b_addr = 24'h000777; b_din = 32'hCAFEF00D;
    for (int k = 1; k <= 8 && ack_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_run++;
        if (b_bwe !== 1'b1 || b_bdin !== 32'hCAFEF00D) begin
          n_fail++;
          $display("FAIL b2b_wr got we=%b din=%h exp 1 cafef00d", b_bwe, b_bdin);
        end
        b_req = 1'b0;
      end
      if (b_ack === 1'b1) ack_at = k;
    end
    n_run++;
    if (ack_at != 2 || b_rdout !== saved) begin
      n_fail++;
      $display("FAIL b2b_wr_keep got ack_at=%0d dout=%h exp 2 %h", ack_at, b_rdout, saved);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_delay();
    test_round_robin();
    test_drop_after_grant();
    test_back_to_back();
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d left exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
